trace_stream_receiver: RTL and testbench

// - AXI-Stream slave that consumes trace packets from the continuous monitoring system's M_AXIS port.
// - Buffers each beat in a FIFO and unpacks it into pc/instr, with valid/ready on the output side.
// - Checks frame framing: tlast must land every tlast_interval beats, or on a WFI packet.
// - Consumer side feeds on-chip trace checkers and loopback test harnesses.
//

---
 rtl/trace_stream_receiver_if.sv | 29 ++
 rtl/trace_stream_receiver.sv | 181 ++++++++++++++++++
 tb/tb_trace_stream_receiver.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_stream_receiver_if.sv
// Trace stream bundle: AXI-Stream input beats plus the unpacked pc/instr
// output channel. The receiver uses the slave modport. The producer/consumer
// side (bench or upstream logic) uses the master modport.
interface trace_stream_receiver_if #(
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DATA_WIDTH  = PC_WIDTH + INSTR_WIDTH
);
   logic                   S_AXIS_tvalid;
   logic                   S_AXIS_tready;
   logic [DATA_WIDTH-1:0]  S_AXIS_tdata;
   logic                   S_AXIS_tlast;

   logic                   out_valid;
   logic                   out_ready;
   logic [PC_WIDTH-1:0]    out_pc;
   logic [INSTR_WIDTH-1:0] out_instr;
   logic                   out_last;

   modport slave (
      input  S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
      output S_AXIS_tready, out_valid, out_pc, out_instr, out_last
   );

   modport master (
      output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
      input  S_AXIS_tready, out_valid, out_pc, out_instr, out_last
   );
endinterface

// File: rtl/trace_stream_receiver.sv
// trace_stream_receiver: AXI-Stream slave for trace packets {pc, instr}.
// Each accepted beat goes into a first-word-fall-through FIFO and appears on
// the out_* channel one cycle later. Every accepted beat is also checked for
// framing: tlast is expected every tlast_interval beats, or on a WFI beat.
// Optional build macro TRACE_RX_STATS_EN adds saturating beat/frame/stall
// counters and the stats_clear input.
// DATA_WIDTH must equal PC_WIDTH + INSTR_WIDTH. FIFO_DEPTH must be a power of two, >= 2.
module trace_stream_receiver #(
   parameter int                     PC_WIDTH        = 32,
   parameter int                     INSTR_WIDTH     = 32,
   parameter int                     DATA_WIDTH      = 64,
   parameter int                     FIFO_DEPTH      = 16,
   parameter logic [INSTR_WIDTH-1:0] WFI_INSTRUCTION = 'h1050_0073
) (
   input  logic                   clk,
   input  logic                   rst_n,
   trace_stream_receiver_if.slave axis,
   input  logic [31:0]            tlast_interval,
   output logic                   wfi_seen,
   output logic                   frame_err,
   output logic                   frame_err_pulse,
   input  logic                   err_clear
`ifdef TRACE_RX_STATS_EN
   ,
   input  logic                   stats_clear,
   output logic [31:0]            stat_beats,
   output logic [31:0]            stat_frames,
   output logic [31:0]            stat_stalls
`endif
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   // Storage word is {tlast, tdata}. It is not reset; the pointers define validity.
   logic [DATA_WIDTH:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_tready;

   logic [31:0]          r_beat_cnt;
   logic                 r_wfi_seen;
   logic                 r_frame_err;
   logic                 r_err_pulse;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_empty;
   logic [CNT_W-1:0]     w_count_nxt;
   logic [DATA_WIDTH:0]  w_rd_word;
   logic [INSTR_WIDTH-1:0] w_beat_instr;
   logic                 w_is_wfi;
   logic                 w_exp_last;
   logic                 w_mismatch;

   assign w_empty = (r_count == '0);
   assign w_push  = axis.S_AXIS_tvalid & r_tready;
   assign w_pop   = axis.out_ready & ~w_empty;

   // Occupancy after this edge; drives the registered tready so a pop while full
   // cannot reopen the input in the same cycle.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   // FIFO pointers, occupancy and tready; tready stays low until the first edge out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_tready <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count  <= w_count_nxt;
         r_tready <= (w_count_nxt != DEPTH_C);
      end
   end

   // Beat storage.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {axis.S_AXIS_tlast, axis.S_AXIS_tdata};
      end
   end

   // First-word-fall-through read; outputs are zero while empty.
   assign w_rd_word       = w_empty ? '0 : r_mem[r_rd_ptr];
   assign axis.out_valid  = ~w_empty;
   assign axis.out_last   = w_rd_word[DATA_WIDTH];
   assign axis.out_pc     = w_rd_word[DATA_WIDTH-1:INSTR_WIDTH];
   assign axis.out_instr  = w_rd_word[INSTR_WIDTH-1:0];
   assign axis.S_AXIS_tready = r_tready;

   // Framing rule for the beat currently offered.
   assign w_beat_instr = axis.S_AXIS_tdata[INSTR_WIDTH-1:0];
   assign w_is_wfi     = (w_beat_instr == WFI_INSTRUCTION);
   assign w_exp_last   = ((tlast_interval != 32'd0) && ((r_beat_cnt + 32'd1) == tlast_interval))
                         || w_is_wfi;
   assign w_mismatch   = (axis.S_AXIS_tlast != w_exp_last);

   // Frame checker state; err_clear overrides and skips the check of a same-cycle beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat_cnt  <= '0;
         r_wfi_seen  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_pulse <= 1'b0;
      end else if (err_clear) begin
         r_beat_cnt  <= '0;
         r_wfi_seen  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= w_push & w_mismatch;
         if (w_push) begin
            if (w_mismatch) begin
               r_frame_err <= 1'b1;
            end
            if (w_is_wfi) begin
               r_wfi_seen <= 1'b1;
            end
            r_beat_cnt <= axis.S_AXIS_tlast ? 32'd0 : (r_beat_cnt + 32'd1);
         end
      end
   end

   assign wfi_seen        = r_wfi_seen;
   assign frame_err       = r_frame_err;
   assign frame_err_pulse = r_err_pulse;

`ifdef TRACE_RX_STATS_EN
   logic [31:0] r_stat_beats;
   logic [31:0] r_stat_frames;
   logic [31:0] r_stat_stalls;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
   endfunction

   // Saturating statistics; stats_clear wins over any same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_beats  <= '0;
         r_stat_frames <= '0;
         r_stat_stalls <= '0;
      end else if (stats_clear) begin
         r_stat_beats  <= '0;
         r_stat_frames <= '0;
         r_stat_stalls <= '0;
      end else begin
         if (w_push) begin
            r_stat_beats <= sat_inc(r_stat_beats);
         end
         if (w_push && axis.S_AXIS_tlast) begin
            r_stat_frames <= sat_inc(r_stat_frames);
         end
         if (axis.S_AXIS_tvalid && !r_tready) begin
            r_stat_stalls <= sat_inc(r_stat_stalls);
         end
      end
   end

   assign stat_beats  = r_stat_beats;
   assign stat_frames = r_stat_frames;
   assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_trace_stream_receiver.sv
// Bench for trace_stream_receiver: directed framing scenarios plus randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_trace_stream_receiver;
   localparam int          PCW   = 32;
   localparam int          IW    = 32;
   localparam int          DW    = 64;
   localparam int          DEPTH = 16;
   localparam logic [31:0] WFI   = 32'h1050_0073;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] tlast_interval = 32'd0;
   logic        err_clear = 1'b0;
   logic        wfi_seen;
   logic        frame_err;
   logic        frame_err_pulse;
`ifdef TRACE_RX_STATS_EN
   logic        stats_clear = 1'b0;
   logic [31:0] stat_beats;
   logic [31:0] stat_frames;
   logic [31:0] stat_stalls;
`endif

   trace_stream_receiver_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

   trace_stream_receiver #(
      .PC_WIDTH(PCW), .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
   ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .axis            (bus.slave),
      .tlast_interval  (tlast_interval),
      .wfi_seen        (wfi_seen),
      .frame_err       (frame_err),
      .frame_err_pulse (frame_err_pulse),
      .err_clear       (err_clear)
`ifdef TRACE_RX_STATS_EN
      ,
      .stats_clear     (stats_clear),
      .stat_beats      (stat_beats),
      .stat_frames     (stat_frames),
      .stat_stalls     (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        last;
   } ent_t;

   ent_t        m_q[$];
   bit          m_armed = 0;
   bit          m_wfi = 0;
   bit          m_ferr = 0;
   bit          m_pulse = 0;
   logic [31:0] m_bcnt = 32'd0;
   int          m_accepted = 0;
   logic [31:0] m_beats = 32'd0;
   logic [31:0] m_frames = 32'd0;
   logic [31:0] m_stalls = 32'd0;

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Compare at the falling edge, then advance the model across the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_q.delete();
         m_armed = 0; m_wfi = 0; m_ferr = 0; m_pulse = 0; m_bcnt = 32'd0;
         m_beats = 32'd0; m_frames = 32'd0; m_stalls = 32'd0;
         check("rst_tready", 64'(bus.S_AXIS_tready), 64'd0);
         check("rst_out_valid", 64'(bus.out_valid), 64'd0);
         check("rst_out_word", {bus.out_pc, bus.out_instr}, 64'd0);
         check("rst_out_last", 64'(bus.out_last), 64'd0);
         check("rst_flags", {61'd0, wfi_seen, frame_err, frame_err_pulse}, 64'd0);
      end else begin
         bit   exp_tready, push, pop, stall, exp_last;
         ent_t e;
         exp_tready = m_armed && (m_q.size() < DEPTH);
         check("tready", 64'(bus.S_AXIS_tready), 64'(exp_tready));
         check("out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            check("out_word", {bus.out_pc, bus.out_instr}, {m_q[0].pc, m_q[0].instr});
            check("out_last", 64'(bus.out_last), 64'(m_q[0].last));
         end else begin
            check("out_word_idle", {bus.out_pc, bus.out_instr}, 64'd0);
         end
         check("wfi_seen", 64'(wfi_seen), 64'(m_wfi));
         check("frame_err", 64'(frame_err), 64'(m_ferr));
         check("frame_err_pulse", 64'(frame_err_pulse), 64'(m_pulse));
`ifdef TRACE_RX_STATS_EN
         check("stat_beats", 64'(stat_beats), 64'(m_beats));
         check("stat_frames", 64'(stat_frames), 64'(m_frames));
         check("stat_stalls", 64'(stat_stalls), 64'(m_stalls));
`endif
         push  = bus.S_AXIS_tvalid && exp_tready;
         pop   = bus.out_ready && (m_q.size() != 0);
         stall = bus.S_AXIS_tvalid && !exp_tready;
         e.pc    = bus.S_AXIS_tdata[63:32];
         e.instr = bus.S_AXIS_tdata[31:0];
         e.last  = bus.S_AXIS_tlast;
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back(e);
            m_accepted++;
         end
         if (err_clear) begin
            m_wfi = 0; m_ferr = 0; m_bcnt = 32'd0; m_pulse = 0;
         end else begin
            exp_last = ((tlast_interval != 0) && ((m_bcnt + 32'd1) == tlast_interval))
                       || (e.instr == WFI);
            m_pulse = push && (e.last != exp_last);
            if (push) begin
               if (e.last != exp_last) m_ferr = 1;
               if (e.instr == WFI) m_wfi = 1;
               m_bcnt = e.last ? 32'd0 : m_bcnt + 32'd1;
            end
         end
`ifdef TRACE_RX_STATS_EN
         if (stats_clear) begin
            m_beats = 32'd0; m_frames = 32'd0; m_stalls = 32'd0;
         end else begin
            if (push) m_beats = sat(m_beats);
            if (push && e.last) m_frames = sat(m_frames);
            if (stall) m_stalls = sat(m_stalls);
         end
`endif
         m_armed = 1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic last);
      int start;
      int guard;
      start = m_accepted;
      guard = 0;
      bus.S_AXIS_tvalid = 1'b1;
      bus.S_AXIS_tdata  = {pc, instr};
      bus.S_AXIS_tlast  = last;
      while (m_accepted == start && guard < 200) begin
         tick();
         guard++;
      end
      if (guard >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: actual not accepted required accepted");
      end
      bus.S_AXIS_tvalid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      bus.out_ready = 1'b1;
      while (m_q.size() != 0 && guard < 100) begin
         tick();
         guard++;
      end
   endtask

   task automatic pulse_err_clear();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
   endtask

   initial begin
      int start;
      bus.S_AXIS_tvalid = 1'b0;
      bus.S_AXIS_tdata  = '0;
      bus.S_AXIS_tlast  = 1'b0;
      bus.out_ready     = 1'b1;

      // Reset and release
      repeat (3) tick();
      check("lit_tready_in_reset", 64'(bus.S_AXIS_tready), 64'd0);
      rst_n = 1'b1;
      check("lit_tready_at_release", 64'(bus.S_AXIS_tready), 64'd0);
      tick();
      check("lit_tready_after_edge", 64'(bus.S_AXIS_tready), 64'd1);

      // Two well-formed frames of 4, one-cycle latency to the output
      tlast_interval = 32'd4;
      for (int i = 0; i < 8; i++) begin
         send(32'h1000 + 32'(4 * i), 32'h0000_0013 + 32'(i << 7), (i % 4) == 3);
         check("lit_latency_valid", 64'(bus.out_valid), 64'd1);
         check("lit_latency_pc", 64'(bus.out_pc), 64'(32'h1000 + 32'(4 * i)));
      end
      check("lit_frame_ok", 64'(frame_err), 64'd0);

      // Early tlast on beat 3
      send(32'h2000, 32'h13, 1'b0);
      send(32'h2004, 32'h13, 1'b0);
      send(32'h2008, 32'h13, 1'b1);
      check("lit_early_pulse", 64'(frame_err_pulse), 64'd1);
      check("lit_early_sticky", 64'(frame_err), 64'd1);
      for (int i = 0; i < 4; i++) begin
         send(32'h3000 + 32'(4 * i), 32'h13, i == 3);
         check("lit_restart_no_pulse", 64'(frame_err_pulse), 64'd0);
      end
      pulse_err_clear();
      check("lit_err_cleared", 64'(frame_err), 64'd0);

      // WFI terminates a frame early
      tlast_interval = 32'd100;
      send(32'h4000, 32'h13, 1'b0);
      send(32'h4004, WFI, 1'b1);
      check("lit_wfi_seen", 64'(wfi_seen), 64'd1);
      check("lit_wfi_no_err", 64'(frame_err), 64'd0);
      send(32'h4008, WFI, 1'b0);
      check("lit_wfi_missing_last", 64'(frame_err), 64'd1);
      pulse_err_clear();
      check("lit_wfi_cleared", 64'(wfi_seen), 64'd0);

      // Fill with the consumer stalled
      drain();
      tlast_interval = 32'd0;
      bus.out_ready  = 1'b0;
`ifdef TRACE_RX_STATS_EN
      stats_clear = 1'b1;
      tick();
      stats_clear = 1'b0;
`endif
      start = m_accepted;
      bus.S_AXIS_tvalid = 1'b1;
      bus.S_AXIS_tlast  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.S_AXIS_tdata = {32'h5000 + 32'(4 * i), 32'h33 + 32'(i)};
         tick();
      end
      bus.S_AXIS_tvalid = 1'b0;
      check("lit_fill_count", 64'(m_accepted - start), 64'd16);
      check("lit_full_tready", 64'(bus.S_AXIS_tready), 64'd0);
      check("lit_full_head", 64'(bus.out_pc), 64'h5000);
`ifdef TRACE_RX_STATS_EN
      check("lit_stat_beats", 64'(stat_beats), 64'd16);
      check("lit_stat_stalls", 64'(stat_stalls), 64'd4);
`endif
      drain();
      check("lit_drained", 64'(bus.out_valid), 64'd0);

      // Random continuous traffic with out_ready toggling
      tlast_interval = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd3;
      start = m_accepted;
      bus.S_AXIS_tvalid = 1'b1;
      for (int i = 0; i < 120; i++) begin
         bus.S_AXIS_tdata = {$urandom(), (($urandom_range(0, 15) == 0) ? WFI : $urandom())};
         bus.S_AXIS_tlast = ($urandom_range(0, 4) == 0);
         err_clear = ($urandom_range(0, 19) == 0);
         bus.out_ready = ~bus.out_ready;
         tick();
      end
      bus.S_AXIS_tvalid = 1'b0;
      err_clear = 1'b0;
      check("lit_wrap_count", 64'(m_accepted - start >= 3 * DEPTH), 64'd1);
      drain();
      pulse_err_clear();

      // Asynchronous reset with entries held, then a clean frame
      tlast_interval = 32'd0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(32'h6000 + 32'(4 * i), 32'h13, 1'b0);
      check("lit_held_valid", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("lit_async_valid", 64'(bus.out_valid), 64'd0);
      check("lit_async_tready", 64'(bus.S_AXIS_tready), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tlast_interval = 32'd4;
      bus.out_ready  = 1'b1;
      for (int i = 0; i < 4; i++) send(32'h7000 + 32'(4 * i), 32'h13, i == 3);
      check("lit_post_reset_frame", 64'(frame_err), 64'd0);
`ifdef TRACE_RX_STATS_EN
      check("lit_post_reset_beats", 64'(stat_beats), 64'd4);
`endif
      drain();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual still running required finished");
      $fatal(1, "timeout");
   end
endmodule
